// File: rtl/psram_arbiter.sv
// psram_arbiter
//   Shares the single 16-bit PSRAM controller command interface between two
//   8-bit byte-addressed requesters. Port A (CPU bus) has priority; port B
//   (boot loader / DMA) is granted when A is idle, or forcibly after
//   A_BURST_MAX consecutive A grants made while B was waiting.
//   Each granted byte request becomes one read/write command pulse. The
//   arbiter then follows the controller's busy handshake and returns the
//   addressed byte lane together with a one-cycle ack.
//
// Ports
//   clock, resetn              PSRAM-domain clock, synchronous active-low reset
//   a_req/a_we/a_addr/a_wdata  port A request (level, held until a_ack)
//   a_rdata/a_ack              port A read byte and completion pulse
//   b_*                        same set for port B
//   mem_read/mem_write         single-cycle command pulses to the controller
//   mem_byte_write             byte-write qualifier (asserted with mem_write)
//   mem_addr/mem_din           command address and write data, held until next grant
//   mem_dout/mem_busy          controller read data and busy
//   err                        sticky flag: busy never rose after a command
//   grant_b                    current/last transaction belongs to port B
module psram_arbiter #(
    parameter int ADDR_W            = 22,
    parameter int A_BURST_MAX       = 4,
    parameter int BUSY_RISE_TIMEOUT = 8
) (
    input  logic              clock,
    input  logic              resetn,
    input  logic              a_req,
    input  logic              a_we,
    input  logic [ADDR_W-1:0] a_addr,
    input  logic [7:0]        a_wdata,
    output logic [7:0]        a_rdata,
    output logic              a_ack,
    input  logic              b_req,
    input  logic              b_we,
    input  logic [ADDR_W-1:0] b_addr,
    input  logic [7:0]        b_wdata,
    output logic [7:0]        b_rdata,
    output logic              b_ack,
    output logic              mem_read,
    output logic              mem_write,
    output logic              mem_byte_write,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [15:0]       mem_din,
    input  logic [15:0]       mem_dout,
    input  logic              mem_busy,
    output logic              err,
    output logic              grant_b
);

    localparam int BURST_W = $clog2(A_BURST_MAX + 1);
    localparam int TO_W    = $clog2(BUSY_RISE_TIMEOUT + 1);
    localparam logic [BURST_W-1:0] BURST_LIM = BURST_W'(A_BURST_MAX);
    localparam logic [TO_W-1:0]    TO_LAST   = TO_W'(BUSY_RISE_TIMEOUT - 1);

    typedef enum logic [2:0] {
        S_INIT,
        S_IDLE,
        S_ISSUE,
        S_WAIT_RISE,
        S_WAIT_FALL,
        S_DONE
    } state_t;

    state_t              state_q, state_d;
    logic [BURST_W-1:0]  burst_q, burst_d;
    logic [TO_W-1:0]     to_cnt_q, to_cnt_d;
    logic                we_q, we_d;
    logic [ADDR_W-1:0]   mem_addr_q, mem_addr_d;
    logic [15:0]         mem_din_q, mem_din_d;
    logic                mem_read_q, mem_read_d;
    logic                mem_write_q, mem_write_d;
    logic [7:0]          a_rdata_q, a_rdata_d;
    logic [7:0]          b_rdata_q, b_rdata_d;
    logic                a_ack_q, a_ack_d;
    logic                b_ack_q, b_ack_d;
    logic                err_q, err_d;
    logic                grant_b_q, grant_b_d;

    logic                pick_b;
    logic                win_we;
    logic [7:0]          rd_byte;

    always_comb begin
        state_d     = state_q;
        burst_d     = burst_q;
        to_cnt_d    = to_cnt_q;
        we_d        = we_q;
        mem_addr_d  = mem_addr_q;
        mem_din_d   = mem_din_q;
        mem_read_d  = 1'b0;
        mem_write_d = 1'b0;
        a_rdata_d   = a_rdata_q;
        b_rdata_d   = b_rdata_q;
        a_ack_d     = 1'b0;
        b_ack_d     = 1'b0;
        err_d       = err_q;
        grant_b_d   = grant_b_q;
        pick_b      = 1'b0;
        win_we      = 1'b0;
        rd_byte     = mem_addr_q[0] ? mem_dout[15:8] : mem_dout[7:0];

        case (state_q)
            S_INIT: begin
                // Controller power-up: one sampled cycle of busy low is enough.
                if (!mem_busy) state_d = S_IDLE;
            end
            S_IDLE: begin
                pick_b = b_req && (!a_req || burst_q == BURST_LIM);
                win_we = pick_b ? b_we : a_we;
                // The ack cycle is skipped so a requester still holding req
                // while it sees its ack is not serviced twice.
                if (!a_ack_q && !b_ack_q && (a_req || b_req)) begin
                    grant_b_d   = pick_b;
                    we_d        = win_we;
                    mem_addr_d  = pick_b ? b_addr : a_addr;
                    mem_din_d   = pick_b ? {b_wdata, b_wdata} : {a_wdata, a_wdata};
                    mem_read_d  = !win_we;
                    mem_write_d = win_we;
                    // Count only A grants that made B wait.
                    if (pick_b || !b_req) burst_d = '0;
                    else                  burst_d = burst_q + 1'b1;
                    state_d = S_ISSUE;
                end
            end
            S_ISSUE: begin
                to_cnt_d = '0;
                state_d  = S_WAIT_RISE;
            end
            S_WAIT_RISE: begin
                if (mem_busy) begin
                    state_d = S_WAIT_FALL;
                end else if (to_cnt_q == TO_LAST) begin
                    err_d   = 1'b1;
                    state_d = S_DONE;
                end else begin
                    to_cnt_d = to_cnt_q + 1'b1;
                end
            end
            S_WAIT_FALL: begin
                if (!mem_busy) state_d = S_DONE;
            end
            S_DONE: begin
                if (!we_q) begin
                    if (grant_b_q) b_rdata_d = rd_byte;
                    else           a_rdata_d = rd_byte;
                end
                a_ack_d = !grant_b_q;
                b_ack_d = grant_b_q;
                state_d = S_IDLE;
            end
            default: state_d = S_INIT;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetn) begin
            state_q     <= S_INIT;
            burst_q     <= '0;
            to_cnt_q    <= '0;
            we_q        <= 1'b0;
            mem_addr_q  <= '0;
            mem_din_q   <= '0;
            mem_read_q  <= 1'b0;
            mem_write_q <= 1'b0;
            a_rdata_q   <= '0;
            b_rdata_q   <= '0;
            a_ack_q     <= 1'b0;
            b_ack_q     <= 1'b0;
            err_q       <= 1'b0;
            grant_b_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            burst_q     <= burst_d;
            to_cnt_q    <= to_cnt_d;
            we_q        <= we_d;
            mem_addr_q  <= mem_addr_d;
            mem_din_q   <= mem_din_d;
            mem_read_q  <= mem_read_d;
            mem_write_q <= mem_write_d;
            a_rdata_q   <= a_rdata_d;
            b_rdata_q   <= b_rdata_d;
            a_ack_q     <= a_ack_d;
            b_ack_q     <= b_ack_d;
            err_q       <= err_d;
            grant_b_q   <= grant_b_d;
        end
    end

    assign mem_read       = mem_read_q;
    assign mem_write      = mem_write_q;
    assign mem_byte_write = mem_write_q;
    assign mem_addr       = mem_addr_q;
    assign mem_din        = mem_din_q;
    assign a_rdata        = a_rdata_q;
    assign b_rdata        = b_rdata_q;
    assign a_ack          = a_ack_q;
    assign b_ack          = b_ack_q;
    assign err            = err_q;
    assign grant_b        = grant_b_q;

endmodule
